abs_diff_sched: RTL and testbench
=================================

# abs_diff_sched

Time-multiplexed scheduler for the absolute-difference stage of the R-peak detection pipeline. It accepts one ECG sample with its short and long moving averages over a valid/ready handshake. It computes |sample − MA_short| and |sample − MA_long| sequentially on a single shared subtract/absolute unit, then presents both results to the downstream detector over a valid/ready handshake. It sits between the moving-average filters and the threshold/peak-search logic.

## Interface
- DATA_WIDTH, 11, signed width of samples, averages and results
- CNT_WIDTH, 16, width of processed-sample counter
- i_clk  in  1  clock, all logic rising-edge
- i_rst  in  1  reset, asynchronous, active-high
- i_sample_valid  in  1  upstream sample + averages valid
- o_sample_ready  out  1  scheduler accepts sample this cycle
- i_ecg_sample  in  DATA_WIDTH  signed ECG sample
- i_ma_short  in  DATA_WIDTH  signed short-window average
- i_ma_long  in  DATA_WIDTH  signed long-window average
- i_ma_short_valid  in  1  short average meaningful (window filled)
- i_ma_long_valid  in  1  long average meaningful
- o_valid  out  1  result set available
- i_out_ready  in  1  downstream accepts result set
- o_ecg_sample  out  DATA_WIDTH  sample passed through, aligned with results
- o_abs_diff_short  out  DATA_WIDTH  |sample − MA_short|, saturated
- o_abs_diff_long  out  DATA_WIDTH  |sample − MA_long|, saturated
- o_short_ok  out  1  short result valid (MA_short was valid at capture)
- o_long_ok  out  1  long result valid
- o_sample_cnt  out  CNT_WIDTH  count of result sets delivered, wraps
- o_sat_cnt  out  8  saturation events, only with ABS_DIFF_SCHED_STATS_EN

## Operation
- FSM states: IDLE, CALC_S, CALC_L, HOLD; reset state IDLE.
- IDLE: o_sample_ready=1. On i_sample_valid, capture sample, both averages and both MA valid flags, then go to CALC_S. Otherwise stay.
- CALC_S: shared unit gets (sample, MA_short). Register the result into o_abs_diff_short and the flag into o_short_ok. Go to CALC_L.
- CALC_L: shared unit gets (sample, MA_long). Register the result into o_abs_diff_long and the flag into o_long_ok. Copy the captured sample to o_ecg_sample. Go to HOLD.
- HOLD: o_valid=1, outputs stable. On i_out_ready, increment o_sample_cnt and go to IDLE.
- o_sample_ready=0 in every state except IDLE. A sample offered in HOLD is not accepted, even when i_out_ready is high the same cycle. It is accepted in the following IDLE cycle.
- Arithmetic: difference computed at DATA_WIDTH+1 bits, absolute value taken, result saturated to 2^(DATA_WIDTH−1)−1. With DATA_WIDTH=11: 0 − (−1024) → 1023; 1023 − (−1024) → 1023.
- If the MA valid flag was 0 at capture, the result is forced to 0, the ok flag is 0, and the slot still consumes its cycle.
- o_sample_cnt wraps from 2^CNT_WIDTH−1 to 0.
- Reset at any time: FSM to IDLE, in-flight sample discarded, all outputs 0.

## Timing
- Reset values: o_sample_ready=0 while i_rst high, 1 in the first IDLE cycle after release. Every other output is 0.
- Handshake in cycle T (IDLE): CALC_S in T+1, CALC_L in T+2, o_valid=1 from T+3.
- With i_out_ready=1 at T+3: IDLE at T+4, next handshake possible at T+4. Minimum period is 4 cycles per sample.
- o_valid holds until accepted. o_ecg_sample, the results and the flags are stable throughout HOLD.
- All outputs are registered. o_sample_ready and o_valid decode directly from the state register.

## Configuration
- ABS_DIFF_SCHED_STATS_EN defined:
  - o_sat_cnt port present.
  - Increments by 1 for each CALC_S or CALC_L computation that saturated and whose MA flag was valid.
  - Saturates at 255; cleared only by reset.
- Undefined: o_sat_cnt port and counter are absent; all other behaviour is identical.

## Structure
- Shared package abs_diff_pkg holds:
  - state enum sched_state_t (IDLE, CALC_S, CALC_L, HOLD);
  - function or localparam for the saturation limit derived from DATA_WIDTH.
- Sub-module abs_sat_unit: combinational, signed a, b in; |a−b| saturated out; sat flag out. Instantiated once and shared between both slots by an operand mux driven by the state.

## Test plan
- Reset release, sample=100, MA_s=40, MA_l=150, both valid, i_out_ready=1 → o_valid at T+3 with short=60, long=50, both ok=1, o_ecg_sample=100, o_sample_cnt=1.
- Sample=−1024, MA_s=0, MA_l=1023 → short=1023, long=1023. With macro defined, o_sat_cnt +2.
- MA_long_valid=0, sample=10, MA_s=5 → short=5, o_short_ok=1, long=0, o_long_ok=0.
- i_out_ready=0 for 10 cycles in HOLD while new i_sample_valid is held high:
  - o_valid stays 1, outputs stable, o_sample_ready=0 throughout;
  - after i_out_ready pulses, the new sample is accepted in the next cycle.
- Assert i_rst during CALC_L → all outputs 0 immediately, no o_valid for that sample, o_sample_cnt=0.
- Stream 70000 back-to-back samples, i_out_ready=1 → one result every 4 cycles, o_sample_cnt wraps past 65535 to 0.

Source files
------------

// File: rtl/abs_diff_sched_pkg.sv
// Shared types and helpers for the abs_diff_sched scheduler.
// Holds the FSM state type and the saturation limit derived from the data width.
package abs_diff_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_S = 2'd1,
    CALC_L = 2'd2,
    HOLD   = 2'd3
  } sched_state_t;

  // Largest positive value representable in a signed word of the given width
  function automatic int sat_limit(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/abs_diff_sched_if.sv
// Upstream sample and downstream result handshakes for abs_diff_sched.
// o_sat_cnt exists only when ABS_DIFF_SCHED_STATS_EN is defined.
interface abs_diff_sched_if #(
  parameter int DATA_WIDTH = 11,
  parameter int CNT_WIDTH  = 16
);
  logic                         i_sample_valid;
  logic                         o_sample_ready;
  logic signed [DATA_WIDTH-1:0] i_ecg_sample;
  logic signed [DATA_WIDTH-1:0] i_ma_short;
  logic signed [DATA_WIDTH-1:0] i_ma_long;
  logic                         i_ma_short_valid;
  logic                         i_ma_long_valid;
  logic                         o_valid;
  logic                         i_out_ready;
  logic signed [DATA_WIDTH-1:0] o_ecg_sample;
  logic signed [DATA_WIDTH-1:0] o_abs_diff_short;
  logic signed [DATA_WIDTH-1:0] o_abs_diff_long;
  logic                         o_short_ok;
  logic                         o_long_ok;
  logic [CNT_WIDTH-1:0]         o_sample_cnt;
`ifdef ABS_DIFF_SCHED_STATS_EN
  logic [7:0]                   o_sat_cnt;
`endif

  modport slave (
    input  i_sample_valid, i_ecg_sample, i_ma_short, i_ma_long,
    input  i_ma_short_valid, i_ma_long_valid, i_out_ready,
`ifdef ABS_DIFF_SCHED_STATS_EN
    output o_sat_cnt,
`endif
    output o_sample_ready, o_valid, o_ecg_sample, o_abs_diff_short,
    output o_abs_diff_long, o_short_ok, o_long_ok, o_sample_cnt
  );

  modport master (
    output i_sample_valid, i_ecg_sample, i_ma_short, i_ma_long,
    output i_ma_short_valid, i_ma_long_valid, i_out_ready,
`ifdef ABS_DIFF_SCHED_STATS_EN
    input  o_sat_cnt,
`endif
    input  o_sample_ready, o_valid, o_ecg_sample, o_abs_diff_short,
    input  o_abs_diff_long, o_short_ok, o_long_ok, o_sample_cnt
  );

endinterface

// File: rtl/abs_diff_sched_abs_sat.sv
// Combinational |a - b| with saturation to the largest positive signed value.
// The difference is formed one bit wider so it can never overflow.
module abs_sat_unit
  import abs_diff_pkg::*;
#(
  parameter int DATA_WIDTH = 11
) (
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0] abs_o,
  output logic                         sat_o
);

  localparam int                LIMIT_INT = sat_limit(DATA_WIDTH);
  localparam logic [DATA_WIDTH:0] LIMIT   = LIMIT_INT[DATA_WIDTH:0];

  logic signed [DATA_WIDTH:0] diff;
  logic        [DATA_WIDTH:0] mag;

  always_comb begin
    diff  = {a_i[DATA_WIDTH-1], a_i} - {b_i[DATA_WIDTH-1], b_i};
    mag   = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    sat_o = (mag > LIMIT);
    abs_o = sat_o ? $signed(LIMIT[DATA_WIDTH-1:0]) : $signed(mag[DATA_WIDTH-1:0]);
  end

endmodule

// File: rtl/abs_diff_sched.sv
// Time-multiplexed |sample - MA_short| / |sample - MA_long| scheduler, one shared unit.
// Optional saturation statistics counter enabled by ABS_DIFF_SCHED_STATS_EN.
module abs_diff_sched
  import abs_diff_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int CNT_WIDTH  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  abs_diff_sched_if.slave bus
);

  sched_state_t                 state_q;
  logic signed [DATA_WIDTH-1:0] sample_q, ma_s_q, ma_l_q;
  logic                         ma_s_ok_q, ma_l_ok_q;
  logic signed [DATA_WIDTH-1:0] ecg_q, abs_s_q, abs_l_q;
  logic                         short_ok_q, long_ok_q;
  logic [CNT_WIDTH-1:0]         cnt_q;

  logic signed [DATA_WIDTH-1:0] op_b;
  logic                         op_ok;
  logic signed [DATA_WIDTH-1:0] unit_abs;
  logic                         unit_sat;

  // Operand mux: the short slot is the default, CALC_L switches to the long average
  assign op_b  = (state_q == CALC_L) ? ma_l_q    : ma_s_q;
  assign op_ok = (state_q == CALC_L) ? ma_l_ok_q : ma_s_ok_q;

  abs_sat_unit #(.DATA_WIDTH(DATA_WIDTH)) u_abs (
    .a_i   (sample_q),
    .b_i   (op_b),
    .abs_o (unit_abs),
    .sat_o (unit_sat)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      sample_q   <= '0;
      ma_s_q     <= '0;
      ma_l_q     <= '0;
      ma_s_ok_q  <= 1'b0;
      ma_l_ok_q  <= 1'b0;
      ecg_q      <= '0;
      abs_s_q    <= '0;
      abs_l_q    <= '0;
      short_ok_q <= 1'b0;
      long_ok_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.i_sample_valid) begin
          sample_q  <= bus.i_ecg_sample;
          ma_s_q    <= bus.i_ma_short;
          ma_l_q    <= bus.i_ma_long;
          ma_s_ok_q <= bus.i_ma_short_valid;
          ma_l_ok_q <= bus.i_ma_long_valid;
          state_q   <= CALC_S;
        end
        CALC_S: begin
          abs_s_q    <= op_ok ? unit_abs : '0;
          short_ok_q <= op_ok;
          state_q    <= CALC_L;
        end
        CALC_L: begin
          abs_l_q   <= op_ok ? unit_abs : '0;
          long_ok_q <= op_ok;
          ecg_q     <= sample_q;
          state_q   <= HOLD;
        end
        HOLD: if (bus.i_out_ready) begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is masked while reset is held so nothing is offered before release
  assign bus.o_sample_ready   = (state_q == IDLE) && !i_rst;
  assign bus.o_valid          = (state_q == HOLD);
  assign bus.o_ecg_sample     = ecg_q;
  assign bus.o_abs_diff_short = abs_s_q;
  assign bus.o_abs_diff_long  = abs_l_q;
  assign bus.o_short_ok       = short_ok_q;
  assign bus.o_long_ok        = long_ok_q;
  assign bus.o_sample_cnt     = cnt_q;

`ifdef ABS_DIFF_SCHED_STATS_EN
  logic [7:0] sat_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sat_cnt_q <= '0;
    end else if ((state_q == CALC_S || state_q == CALC_L) && op_ok && unit_sat
                 && sat_cnt_q != 8'hFF) begin
      sat_cnt_q <= sat_cnt_q + 8'd1;
    end
  end

  assign bus.o_sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_abs_diff_sched.sv
// Self-checking bench for abs_diff_sched: vector table, hand-written corner
// sequences and a random stream checked against an arithmetic reference model.
module tb_abs_diff_sched;

  localparam int DW  = 11;
  localparam int CW  = 10;
  localparam int LIM = (1 << (DW - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  abs_diff_sched_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  abs_diff_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  int exp_sat = 0;

  typedef struct {
    int s; int ms; int ml; bit vs; bit vl;
    int es; int el; bit oks; bit okl;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_mag(input int s, input int m);
    int d;
    d = s - m;
    return (d < 0) ? -d : d;
  endfunction

  function automatic int model_abs(input int s, input int m, input bit v);
    int d;
    if (!v) return 0;
    d = model_mag(s, m);
    return (d > LIM) ? LIM : d;
  endfunction

  function automatic bit model_sat(input int s, input int m, input bit v);
    return v && (model_mag(s, m) > LIM);
  endfunction

  task automatic drive(input int s, input int ms, input int ml, input bit vs, input bit vl);
    bus.i_ecg_sample     = DW'(s);
    bus.i_ma_short       = DW'(ms);
    bus.i_ma_long        = DW'(ml);
    bus.i_ma_short_valid = vs;
    bus.i_ma_long_valid  = vl;
  endtask

  task automatic note_sat(input int s, input int ms, input int ml, input bit vs, input bit vl);
    if (model_sat(s, ms, vs) && exp_sat < 255) exp_sat++;
    if (model_sat(s, ml, vl) && exp_sat < 255) exp_sat++;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.o_sample_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic get_result(input string tag, input int es, input int el,
                            input bit oks, input bit okl, input int s);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.o_valid && lat < 10);
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_short"}, int'(bus.o_abs_diff_short), es);
    chk({tag, "_long"}, int'(bus.o_abs_diff_long), el);
    chk({tag, "_short_ok"}, int'(bus.o_short_ok), int'(oks));
    chk({tag, "_long_ok"}, int'(bus.o_long_ok), int'(okl));
    chk({tag, "_ecg"}, int'(bus.o_ecg_sample), s);
    $display("txn %s: s=%0d short=%0d long=%0d ok=%0d%0d cnt=%0d",
             tag, s, bus.o_abs_diff_short, bus.o_abs_diff_long,
             bus.o_short_ok, bus.o_long_ok, bus.o_sample_cnt);
  endtask

  task automatic accept(input string tag);
    bus.i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk({tag, "_valid_drop"}, int'(bus.o_valid), 0);
    chk({tag, "_cnt"}, int'(bus.o_sample_cnt), exp_cnt);
`ifdef ABS_DIFF_SCHED_STATS_EN
    chk({tag, "_sat_cnt"}, int'(bus.o_sat_cnt), exp_sat);
`endif
  endtask

  task automatic send(input string tag, input int s, input int ms, input int ml,
                      input bit vs, input bit vl, input int es, input int el,
                      input bit oks, input bit okl, input bit b2b);
    int n;
    @(negedge clk);
    wait_ready(n);
    if (b2b) chk({tag, "_gap"}, n, 0);
    drive(s, ms, ml, vs, vl);
    bus.i_sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_sample_valid = 1'b0;
    note_sat(s, ms, ml, vs, vl);
    get_result(tag, es, el, oks, okl, s);
    accept(tag);
  endtask

  initial begin
    int n, s, ms, ml;
    bit vs, vl;

    vecs[0] = '{100,   40,   150,  1, 1, 60,   50,   1, 1};
    vecs[1] = '{-1024, 0,    1023, 1, 1, 1023, 1023, 1, 1};
    vecs[2] = '{10,    5,    77,   1, 0, 5,    0,    1, 0};
    vecs[3] = '{1023,  -1024, -1024, 1, 1, 1023, 1023, 1, 1};
    vecs[4] = '{0,     -1024, 0,   1, 1, 1023, 0,    1, 1};
    vecs[5] = '{-5,    7,    -5,   0, 1, 0,    0,    0, 1};
    vecs[6] = '{500,   -523, -524, 1, 1, 1023, 1023, 1, 1};
    vecs[7] = '{-300,  200,  -1000, 1, 1, 500, 700,  1, 1};

    bus.i_sample_valid = 1'b0;
    bus.i_out_ready    = 1'b0;
    drive(0, 0, 0, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus.o_sample_ready), 0);
    chk("rst_valid", int'(bus.o_valid), 0);
    chk("rst_cnt", int'(bus.o_sample_cnt), 0);
    chk("rst_short", int'(bus.o_abs_diff_short), 0);
    chk("rst_ecg", int'(bus.o_ecg_sample), 0);
    rst = 1'b0;
    #1;
    chk("rel_ready", int'(bus.o_sample_ready), 1);
    bus.i_out_ready = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send($sformatf("vec%0d", i), vecs[i].s, vecs[i].ms, vecs[i].ml,
           vecs[i].vs, vecs[i].vl, vecs[i].es, vecs[i].el,
           vecs[i].oks, vecs[i].okl, 1'b0);
    end

    // Backpressure in HOLD with a new sample waiting upstream
    bus.i_out_ready = 1'b0;
    @(negedge clk);
    wait_ready(n);
    drive(200, -100, 250, 1'b1, 1'b1);
    bus.i_sample_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(-50, 20, -60, 1'b1, 1'b1);
    get_result("hold_a", 300, 50, 1'b1, 1'b1, 200);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_valid", int'(bus.o_valid), 1);
      chk("hold_ready", int'(bus.o_sample_ready), 0);
      chk("hold_short", int'(bus.o_abs_diff_short), 300);
      chk("hold_long", int'(bus.o_abs_diff_long), 50);
      chk("hold_ecg", int'(bus.o_ecg_sample), 200);
    end
    accept("hold_a");
    @(negedge clk);
    chk("hold_next_ready", int'(bus.o_sample_ready), 1);
    @(posedge clk);
    #1;
    bus.i_sample_valid = 1'b0;
    get_result("hold_b", 70, 10, 1'b1, 1'b1, -50);
    accept("hold_b");

    // Reset while the long slot is being computed
    @(negedge clk);
    drive(100, 40, 150, 1'b1, 1'b1);
    bus.i_sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_sample_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", int'(bus.o_valid), 0);
    chk("midrst_cnt", int'(bus.o_sample_cnt), 0);
    chk("midrst_short", int'(bus.o_abs_diff_short), 0);
    chk("midrst_ok", int'(bus.o_short_ok), 0);
    chk("midrst_ready", int'(bus.o_sample_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    exp_sat = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("midrst_no_valid", int'(bus.o_valid), 0);
    end

    // Random back-to-back stream, long enough to wrap the result counter
    for (int i = 0; i < (1 << CW) + 20; i++) begin
      s  = int'($urandom_range(0, 2047)) - 1024;
      ms = int'($urandom_range(0, 2047)) - 1024;
      ml = int'($urandom_range(0, 2047)) - 1024;
      vs = ($urandom_range(0, 3) != 0);
      vl = ($urandom_range(0, 3) != 0);
      send($sformatf("rnd%0d", i), s, ms, ml, vs, vl,
           model_abs(s, ms, vs), model_abs(s, ml, vl), vs, vl, i != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
